fp_wb_arbiter: RTL
==================

Name: fp_wb_arbiter

Overview:
- Producer side of the FP register file write port. Arbitrates FP writeback requests from the multi-cycle FPU and the load unit (FLW) onto the single write port (fp_we / rd_reg / fp_wdata).
- Registers the winning request for one cycle.
- Maintains a 32-entry pending-write scoreboard. Issue logic uses it to stall reads of FP registers that still have a write outstanding.

Parameters:
DATA_W, 32, FP data width
ADDR_W, 5, register address width
NREGS, 32, number of FP registers (2**ADDR_W)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
fpu_valid  input  1  FPU result valid
fpu_ready  output  1  FPU result accepted this cycle
fpu_rd  input  ADDR_W  FPU destination register
fpu_data  input  DATA_W  FPU result
lsu_valid  input  1  FP load data valid
lsu_ready  output  1  load data accepted this cycle
lsu_rd  input  ADDR_W  load destination register
lsu_data  input  DATA_W  load data
alloc_valid  input  1  issue stage marks alloc_rd as pending
alloc_rd  input  ADDR_W  register being allocated
fp_we  output  1  register file write enable
rd_reg  output  ADDR_W  register file write address
fp_wdata  output  DATA_W  register file write data
busy_vec  output  NREGS  bit i = 1 while write to f[i] pending
alloc_conflict  output  1  one-cycle pulse: allocation hit an already-busy register

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - fp_we=0, rd_reg=0, fp_wdata=0.
  - busy_vec=0, alloc_conflict=0.
  - Priority pointer prefer_lsu=1.
- Grant logic is combinational from valids and the pointer:
  - Only one source valid: that source is granted.
  - Both valid: LSU is granted if prefer_lsu=1, otherwise FPU.
  - Neither valid: no grant.
- fpu_ready / lsu_ready are 1 only for the granted source. At most one is ever 1. Ready is never asserted without the matching valid.
- Handshake rules:
  - Transfer occurs when valid && ready.
  - The loser must hold valid, rd and data stable until granted.
  - The arbiter never drops an accepted request. The register file has no backpressure, so the output stage always accepts.
- Pointer update: on every transfer, prefer_lsu is set to the non-granted source (LSU grant -> prefer_lsu=0; FPU grant -> prefer_lsu=1). No transfer -> pointer holds.
- Output stage latency is one cycle:
  - A transfer in cycle N gives fp_we=1 with rd_reg/fp_wdata equal to the winner's rd/data in cycle N+1.
  - No transfer in cycle N gives fp_we=0 in N+1; rd_reg and fp_wdata hold their last values.
- Back-to-back transfers give one write per cycle.
- Writes to rd=0 are forwarded unchanged; the register file decides whether to commit them.
- Scoreboard, evaluated at each clk edge per bit i:
  - set_i = alloc_valid && alloc_rd==i.
  - clr_i = fp_we && rd_reg==i (the write presented this cycle).
  - set_i=1 -> busy[i]=1; set wins over a simultaneous clr_i, because the new producer supersedes.
  - else clr_i=1 -> busy[i]=0; else hold.
  - Clearing on an entry that is already 0 is a no-op.
- alloc_conflict is registered:
  - It is 1 in cycle N+1 iff, in cycle N, alloc_valid=1, busy[alloc_rd]=1 and NOT clr for alloc_rd.
  - Otherwise it is 0.
  - The allocation still proceeds and busy stays 1.
- busy_vec is a direct register output, not bypassed. A register cleared at edge N reads 0 from cycle N onward, the same cycle its data is readable from the register file.
- Reset asserted mid-operation:
  - All outputs and busy_vec return to their reset values immediately (asynchronously).
  - Any write registered but not yet presented is discarded.
  - The pointer returns to prefer_lsu=1.

Test Plan:
- Reset: hold rst_n=0, drive fpu_valid=1, lsu_valid=1, alloc_valid=1 -> fp_we=0, busy_vec=0, both ready=0 is not required but fp_we must stay 0; release -> first grant goes to LSU.
- Single source: lsu_valid=1, lsu_rd=3, lsu_data=0x3F800000 in cycle 1 -> lsu_ready=1 in cycle 1; fp_we=1, rd_reg=3, fp_wdata=0x3F800000 in cycle 2; fp_we=0 in cycle 3.
- Contention round-robin: both valid for 4 cycles, FPU rd=5/0x40000000, LSU rd=6/0x40400000, each dropping valid after its grant and reasserting a new item -> grants alternate L,F,L,F; writes appear in order 6,5,6,5 one cycle later.
- Scoreboard: alloc rd=7 in cycle 1 -> busy_vec[7]=1 in cycle 2; FPU delivers rd=7 in cycle 4 -> fp_we in cycle 5, busy_vec[7]=0 in cycle 6.
- Set/clear collision: busy[9]=1, write to rd=9 presented (fp_we=1, rd_reg=9) in the same cycle as alloc_valid=1, alloc_rd=9 -> busy[9] stays 1, alloc_conflict=0 next cycle.
- Conflict: busy[2]=1 with no write pending, alloc rd=2 -> alloc_conflict=1 for exactly one cycle, busy[2]=1; async reset in the following cycle -> busy_vec=0 and fp_we=0 immediately.

Source files
------------

// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: round-robin FP writeback arbiter (FPU vs FLW) with pending-write scoreboard
module fp_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fpu_valid,
    output logic              fpu_ready,
    input  logic [ADDR_W-1:0] fpu_rd,
    input  logic [DATA_W-1:0] fpu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_rd,
    output logic              fp_we,
    output logic [ADDR_W-1:0] rd_reg,
    output logic [DATA_W-1:0] fp_wdata,
    output logic [NREGS-1:0]  busy_vec,
    output logic              alloc_conflict
);
    logic              prefer_lsu_q, prefer_lsu_d;
    logic              fp_we_q;
    logic [ADDR_W-1:0] rd_reg_q, rd_reg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              conflict_q, conflict_d;
    logic              grant_lsu, grant_fpu, xfer;
    // grant selection, pointer/output-stage next state, and scoreboard set-over-clear update
    always_comb begin
        busy_d       = busy_q;
        grant_lsu    = lsu_valid && (!fpu_valid || prefer_lsu_q);
        grant_fpu    = fpu_valid && !grant_lsu;
        xfer         = grant_lsu || grant_fpu;
        prefer_lsu_d = xfer ? grant_fpu : prefer_lsu_q;
        rd_reg_d     = grant_lsu ? lsu_rd : grant_fpu ? fpu_rd : rd_reg_q;
        wdata_d      = grant_lsu ? lsu_data : grant_fpu ? fpu_data : wdata_q;
        conflict_d   = alloc_valid && busy_q[alloc_rd] && !(fp_we_q && rd_reg_q == alloc_rd);
        for (int i = 0; i < NREGS; i++)
            busy_d[i] = (alloc_valid && alloc_rd == ADDR_W'(i)) ||
                        (busy_q[i] && !(fp_we_q && rd_reg_q == ADDR_W'(i)));
    end
    // state registers; async reset discards any write not yet presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_lsu_q <= 1'b1;
            fp_we_q      <= 1'b0;
            rd_reg_q     <= '0;
            wdata_q      <= '0;
            busy_q       <= '0;
            conflict_q   <= 1'b0;
        end else begin
            prefer_lsu_q <= prefer_lsu_d;
            fp_we_q      <= xfer;
            rd_reg_q     <= rd_reg_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            conflict_q   <= conflict_d;
        end
    end
    assign fpu_ready      = grant_fpu;
    assign lsu_ready      = grant_lsu;
    assign fp_we          = fp_we_q;
    assign rd_reg         = rd_reg_q;
    assign fp_wdata       = wdata_q;
    assign busy_vec       = busy_q;
    assign alloc_conflict = conflict_q;
endmodule
